// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage pipeline control blocks: jump types,
// hazard controller state and forwarding-select codes.
package pipe_pkg;

    localparam logic [1:0] NO_JUMP = 2'b00;
    localparam logic [1:0] JAL     = 2'b01;
    localparam logic [1:0] JAL_R   = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// 32-bit saturating event counter with synchronous active-low clear.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    // Count events, holding at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 32'd0;
        end else if (i_inc && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, redirect squash, memory freeze
// with timeout. Performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        ex_mem_read,
    input  logic [1:0]  ex_jump_t,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        mem_wb_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pc_redirect,
    output logic        mem_err,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_wait
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    hz_state_t   r_state;
    hz_state_t   w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_mem_err;

    logic        w_mem_stall;
    logic        w_redirect;
    logic        w_load_use;
    logic        w_eval;
    logic        w_freeze;
    logic        w_squash;
    logic        w_bubble;

    assign w_mem_stall = mem_req & ~mem_ready;
    assign w_redirect  = (ex_jump_t != NO_JUMP) | ex_br_taken;
    assign w_load_use  = ex_mem_read & ex_reg_we & (ex_rd != 5'd0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) |
                          (id_use_rs2 & (id_rs2 == ex_rd)));

    // Pick the active action for this cycle, then drive enables and next state.
    always_comb begin
        w_eval         = 1'b0;
        w_freeze       = 1'b0;
        w_squash       = 1'b0;
        w_bubble       = 1'b0;
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = 8'd0;
        pc_we          = 1'b1;
        if_id_we       = 1'b1;
        id_ex_we       = 1'b1;
        ex_mem_we      = 1'b1;
        mem_wb_we      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        pc_redirect    = 1'b0;

        case (r_state)
            RUN:      w_eval = 1'b1;
            LD_STALL: w_freeze = w_mem_stall;
            MEM_WAIT: begin
                if (!mem_ready) begin
                    w_freeze = 1'b1;
                end else begin
                    w_eval = 1'b1;
                end
            end
            default:  w_eval = 1'b0;
        endcase

        // Completion cycle of a wait is evaluated exactly like RUN.
        if (w_eval && w_mem_stall) begin
            w_freeze = 1'b1;
        end else if (w_eval && w_redirect) begin
            w_squash = 1'b1;
        end else if (w_eval && w_load_use) begin
            w_bubble = 1'b1;
        end else begin
            w_squash = 1'b0;
        end

        if (w_freeze) begin
            pc_we          = 1'b0;
            if_id_we       = 1'b0;
            id_ex_we       = 1'b0;
            ex_mem_we      = 1'b0;
            mem_wb_we      = 1'b0;
            w_state_nxt    = MEM_WAIT;
            w_wait_cnt_nxt = (r_state == MEM_WAIT) ? sat_inc8(r_wait_cnt, TIMEOUT) : 8'd1;
        end else if (w_squash) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_bubble) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            w_state_nxt = LD_STALL;
        end else begin
            w_state_nxt = RUN;
        end

        // Reset overrides everything, including a freeze in progress.
        if (!rst_n) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_we    = 1'b0;
            ex_mem_we   = 1'b0;
            mem_wb_we   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_redirect = 1'b0;
        end else begin
            pc_redirect = pc_redirect;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= r_mem_err | (w_freeze & (w_wait_cnt_nxt == TIMEOUT));
        end
    end

    assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_bubble),
        .o_cnt (perf_stall)
    );

    hazard_perf_cnt u_perf_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_squash),
        .o_cnt (perf_flush)
    );

    hazard_perf_cnt u_perf_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_freeze),
        .o_cnt (perf_wait)
    );
`else
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
    assign perf_wait  = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the forwarding unit and sequences the pipeline registers. It inserts a one-cycle bubble on load-use hazards that forwarding cannot cover, squashes IF/ID and ID/EX on a taken jump or branch, and freezes the whole pipeline while the data memory is busy. It also watches memory waits with a timeout counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before `mem_err` sets; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the instruction in ID reads that source
- ex_rd  in  5  destination register of the instruction in EX
- ex_reg_we  in  1  the instruction in EX writes the register file
- ex_mem_read  in  1  the instruction in EX is a load
- ex_jump_t  in  2  jump type in EX (NO_JUMP/JAL/JAL_R)
- ex_br_taken  in  1  conditional branch in EX resolved taken
- mem_req  in  1  a load or store is in MEM
- mem_ready  in  1  data memory completes the access this cycle
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  stage register enables
- if_id_flush, id_ex_flush  out  1  load a bubble into the register
- pc_redirect  out  1  select the EX target as the next PC
- mem_err  out  1  sticky timeout flag, cleared only by reset
- perf_stall, perf_flush, perf_wait  out  32  performance counters

## Operation
- The state register takes one of three values: RUN, LD_STALL and MEM_WAIT. Outputs are combinational from the state and the inputs.
- Default in RUN: all `*_we` = 1; flushes, `pc_redirect` and `mem_err` = 0.
- Priority in RUN, highest first:
  - **Memory wait.** Condition: `mem_req & !mem_ready`. All five `*_we` = 0 and no flush. Next state is MEM_WAIT. The wait counter loads 1.
  - **Redirect.** Condition: `ex_jump_t != NO_JUMP | ex_br_taken`. Outputs: `pc_redirect` = 1, `if_id_flush` = 1, `id_ex_flush` = 1. Next state is RUN. A redirect suppresses any load-use hazard detected in the same cycle.
  - **Load-use.**
    - Condition: `ex_mem_read & ex_reg_we & ex_rd != 0` and the ID instruction uses a source equal to `ex_rd`. A source counts only when its `id_use_*` bit is 1.
    - Outputs: `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1.
    - Next state is LD_STALL.
- **LD_STALL** lasts exactly one cycle:
  - Outputs are the defaults; no hazard is re-evaluated, because EX now holds the bubble.
  - If `mem_req & !mem_ready`, the state goes to MEM_WAIT with the freeze applied. Otherwise it returns to RUN.
- **MEM_WAIT:**
  - While `mem_ready` = 0, all `*_we` = 0 and the wait counter increments.
  - When `mem_ready` = 1, the defaults apply in the same cycle and the next state is RUN. Redirect and load-use are evaluated that cycle with RUN priority.
  - When the counter reaches MEM_TIMEOUT, `mem_err` sets. The state stays in MEM_WAIT and the counter saturates.
- **Reset** (`rst_n` = 0 sampled at an edge):
  - The state goes to RUN and the wait counter and `mem_err` clear.
  - While `rst_n` is low, all `*_we` = 0 and `if_id_flush` = `id_ex_flush` = 1, regardless of state. This includes a reset arriving in the middle of MEM_WAIT.

## Timing
- Decision latency is zero cycles: the outputs respond combinationally to the inputs in the same cycle. The state update takes one clock.
- Load-use costs exactly 1 bubble and a taken jump/branch costs 2 squashed instructions.
- A memory stall of N cycles with `mem_ready` low costs exactly N cycles.
- `mem_err` rises on the edge that completes wait cycle MEM_TIMEOUT.

## Configuration
- `HAZARD_PERF_EN` defined: three 32-bit saturating counters, cleared by reset.
  - `perf_stall` increments on each load-use bubble.
  - `perf_flush` increments on each redirect.
  - `perf_wait` increments on each frozen MEM_WAIT cycle.
- Undefined: the counters are not built and `perf_*` are tied to 0. The ports stay, so instantiations are unchanged.

## Structure
- Shared package `pipe_pkg` holds:
  - the jump-type constants NO_JUMP=2'b00, JAL=2'b01, JAL_R=2'b10;
  - the state encoding RUN/LD_STALL/MEM_WAIT;
  - the forwarding-select constants, which the forwarding unit uses too.
- One sub-module, `hazard_perf_cnt`, is the saturating counter instanced three times. It is built only under `HAZARD_PERF_EN`.

## Test plan
- Load to x5 in EX, ID reads rs1=x5 with `id_use_rs1` = 1 → one cycle with `pc_we` = 0 and `id_ex_flush` = 1, then LD_STALL, then RUN; `perf_stall` = 1.
- Same as above with `ex_rd` = x0, or with `id_use_rs1` = 0 → no stall.
- JAL in EX together with a load-use match → `pc_redirect` = 1 and both flushes = 1, no stall; `perf_flush` = 1.
- `mem_req` = 1 with `mem_ready` low for 3 cycles → all `*_we` = 0 for 3 cycles, released in the cycle `mem_ready` = 1; `perf_wait` = 3.
- MEM_TIMEOUT=4 with `mem_ready` held low for 6 cycles → `mem_err` = 1 after wait cycle 4 and stays set after `mem_ready`.
- `rst_n` low for 1 cycle during MEM_WAIT → next cycle is RUN with defaults; `mem_err` = 0 and the counters = 0.
